seq_ctrl: RTL and testbench

Programmable arbitrary-sequence controller. It holds a DEPTH-entry table of WIDTH-bit codes and plays entries 0..len out on `count`, one per clock, under start/hold/stop control. It asserts `done` on the final beat. It replaces hard-wired arbitrary-sequence counters: the table is rewritten over a simple write port instead of re-coding a case statement. The reset table reproduces the team's standard 7-step sequence 2,9,4,1,6,3,8.

---
 rtl/seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// seq_ctrl: programmable arbitrary-sequence controller.
//
// Holds a DEPTH-entry table of WIDTH-bit codes. On an accepted start it
// plays table[0..len] out on count, one entry per clock. It repeats the
// pass loops+1 times when loop support is built in. It pulses done on
// the final beat.
//
// Optional feature macro: SEQ_CTRL_LOOP_EN. It adds the loops port and
// the repeat counter. Without it every run is a single pass.
//
// Handshake: valid is high for exactly one cycle per new code on count.
// There is no backpressure, so a beat is consumed in the cycle it is
// presented. count keeps its last value whenever valid is low.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (state, outputs and table)
//   wr_en    table write strobe (honoured only while idle)
//   wr_addr  table write index
//   wr_data  table write data
//   len      index of the last entry to play, sampled on accepted start
//   loops    extra repetitions, sampled on accepted start (SEQ_CTRL_LOOP_EN)
//   start    begin playback (ignored while running, blocked by stop)
//   hold     freeze playback while high
//   stop     abort playback, no done
//   count    current code
//   valid    count is a new beat this cycle
//   busy     registered; high exactly while the FSM is in RUN (exposes state)
//   done     one-cycle pulse on the final beat
module seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    len,
`ifdef SEQ_CTRL_LOOP_EN
   input  logic [7:0]       loops,
`endif
   input  logic             start,
   input  logic             hold,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [AW-1:0]    idx, idx_d;
   logic [AW-1:0]    len_q, len_d;
   logic [WIDTH-1:0] count_d;
   logic             valid_d;
   logic             done_d;
   logic             wr_ok;
   logic [WIDTH-1:0] tbl [DEPTH];
`ifdef SEQ_CTRL_LOOP_EN
   logic [7:0]       loop_q, loop_d;
`endif

   // Standard 7-step sequence restored on every reset; the rest are zero.
   function automatic logic [WIDTH-1:0] rst_val(input int i);
      case (i)
         0:       rst_val = WIDTH'(2);
         1:       rst_val = WIDTH'(9);
         2:       rst_val = WIDTH'(4);
         3:       rst_val = WIDTH'(1);
         4:       rst_val = WIDTH'(6);
         5:       rst_val = WIDTH'(3);
         6:       rst_val = WIDTH'(8);
         default: rst_val = '0;
      endcase
   endfunction

   always_comb begin
      state_d = state;
      idx_d   = idx;
      len_d   = len_q;
      count_d = count;
      valid_d = 1'b0;
      done_d  = 1'b0;
      wr_ok   = 1'b0;
`ifdef SEQ_CTRL_LOOP_EN
      loop_d  = loop_q;
`endif
      case (state)
         IDLE: begin
            // Writes are only taken while idle so a run sees a stable table.
            wr_ok = wr_en;
            if (start && !stop) begin
               state_d = RUN;
               idx_d   = '0;
               len_d   = len;
`ifdef SEQ_CTRL_LOOP_EN
               loop_d  = loops;
`endif
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (!hold) begin
               count_d = tbl[idx];
               valid_d = 1'b1;
               if (idx != len_q) begin
                  idx_d = idx + AW'(1);
`ifdef SEQ_CTRL_LOOP_EN
               end else if (loop_q != 8'd0) begin
                  idx_d  = '0;
                  loop_d = loop_q - 8'd1;
`endif
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         len_q <= '0;
         count <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SEQ_CTRL_LOOP_EN
         loop_q <= 8'd0;
`endif
      end else begin
         state <= state_d;
         idx   <= idx_d;
         len_q <= len_d;
         count <= count_d;
         valid <= valid_d;
         busy  <= (state_d == RUN);
         done  <= done_d;
`ifdef SEQ_CTRL_LOOP_EN
         loop_q <= loop_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= rst_val(i);
      end else if (wr_ok) begin
         tbl[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl. A model table is kept here. Each run's expected code
// stream is built as a plain list (passes x entries). Hold, stop and
// ignored writes are driven around it.
module tb_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic [2:0] len;
`ifdef SEQ_CTRL_LOOP_EN
   logic [7:0] loops;
`endif
   logic       start;
   logic       hold;
   logic       stop;
   logic [3:0] count;
   logic       valid;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   logic [3:0] m_tbl [8];
   logic [3:0] m_count;
   logic [3:0] exp_q [$];

   seq_ctrl #(.WIDTH(4), .DEPTH(8), .AW(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .len     (len),
`ifdef SEQ_CTRL_LOOP_EN
      .loops   (loops),
`endif
      .start   (start),
      .hold    (hold),
      .stop    (stop),
      .count   (count),
      .valid   (valid),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      logic [3:0] dflt [8];
      dflt = '{4'd2, 4'd9, 4'd4, 4'd1, 4'd6, 4'd3, 4'd8, 4'd0};
      for (int i = 0; i < 8; i++) m_tbl[i] = dflt[i];
      m_count = 4'd0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
      m_tbl[a] = d;
   endtask

   // hmode: 0 no hold, 1 random hold, 2 hold 3 cycles after hold_at beats.
   // stop_at >= 0 aborts the run once that many beats have been seen.
   task automatic play(input logic [2:0] l, input int lp, input int hmode,
                       input int hold_at, input int stop_at);
      int passes, beats, hleft, cyc, budget;
      bit fin, h, st;
      logic [3:0] e;
`ifdef SEQ_CTRL_LOOP_EN
      passes = lp + 1;
`else
      passes = 1;
`endif
      exp_q.delete();
      for (int p = 0; p < passes; p++)
         for (int i = 0; i <= int'(l); i++) exp_q.push_back(m_tbl[i]);
      budget = exp_q.size() * 4 + 20;
      len = l;
`ifdef SEQ_CTRL_LOOP_EN
      loops = 8'(lp);
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("valid_after_start", 32'(valid), 32'd0);
      beats = 0; hleft = 3; cyc = 0; fin = 0;
      while (!fin && cyc < budget) begin
         st = (stop_at >= 0 && beats == stop_at);
         case (hmode)
            1:       h = ($urandom_range(0, 3) == 0);
            2:       h = (beats == hold_at && hleft > 0);
            default: h = 1'b0;
         endcase
         if (h && hmode == 2) hleft--;
         // Writes during a run must not reach the table.
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = 4'($urandom_range(0, 15));
         hold = h; stop = st;
         tick();
         cyc++;
         if (st) begin
            chk("stop_valid", 32'(valid), 32'd0);
            chk("stop_done", 32'(done), 32'd0);
            chk("stop_busy", 32'(busy), 32'd0);
            chk("stop_count", 32'(count), 32'(m_count));
            fin = 1;
         end else if (h) begin
            chk("hold_valid", 32'(valid), 32'd0);
            chk("hold_count", 32'(count), 32'(m_count));
            chk("hold_done", 32'(done), 32'd0);
         end else begin
            e = exp_q.pop_front();
            m_count = e;
            beats++;
            chk("beat_valid", 32'(valid), 32'd1);
            chk("beat_count", 32'(count), 32'(e));
            chk("beat_done", 32'(done), 32'(exp_q.size() == 0));
            if (exp_q.size() == 0) fin = 1;
         end
      end
      wr_en = 1'b0; hold = 1'b0; stop = 1'b0;
      if (!fin) chk("run_timeout", 32'd0, 32'd1);
      if (stop_at < 0) begin
         tick();
         chk("end_busy", 32'(busy), 32'd0);
         chk("end_valid", 32'(valid), 32'd0);
         chk("end_count", 32'(count), 32'(m_count));
      end
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0;
`ifdef SEQ_CTRL_LOOP_EN
      loops = '0;
`endif
      start = 1'b0; hold = 1'b0; stop = 1'b0;
      model_reset();
      tick(); tick();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      tick();

      // Default sequence 2,9,4,1,6,3,8.
      play(3'd6, 0, 0, 0, -1);

      // Rewritten head, then a rerun after ignored writes during playback.
      wr(3'd0, 4'hF); wr(3'd1, 4'h0); wr(3'd2, 4'hA);
      play(3'd2, 0, 0, 0, -1);
      play(3'd2, 0, 0, 0, -1);

      // Hold for 3 cycles after the beat carrying code 4.
      model_reset();
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      play(3'd6, 0, 2, 3, -1);

      // Stop after the beat 9, then start together with stop is refused.
      play(3'd6, 0, 0, 0, 2);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", 32'(busy), 32'd0);
      chk("startstop_valid", 32'(valid), 32'd0);
      tick();
      chk("startstop_busy2", 32'(busy), 32'd0);

      // len=0 single-beat run.
      play(3'd0, 0, 0, 0, -1);

`ifdef SEQ_CTRL_LOOP_EN
      play(3'd1, 2, 0, 0, -1);
`endif

      // Reset mid-run after rewriting entry 0.
      wr(3'd0, 4'd7);
      len = 3'd6; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("midrun_beat", 32'(count), 32'd9);
      rst_n = 1'b0; hold = 1'b1; stop = 1'b1;
      tick();
      rst_n = 1'b1; hold = 1'b0; stop = 1'b0;
      model_reset();
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      play(3'd0, 0, 0, 0, -1);

      // Randomised runs: idle writes, random len, loops and hold.
      for (int r = 0; r < 8; r++) begin
         for (int w = 0; w < int'($urandom_range(0, 3)); w++)
            wr(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         play(3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1, 0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
